accum_sched: RTL and testbench

ACCUM_SCHED -- requirements
Module: accum_sched

---
 rtl/accum_sched_pkg.sv | 10 +
 rtl/accum_sched_if.sv | 24 ++
 rtl/accum_alu.sv | 20 ++
 rtl/accum_sched.sv | 85 ++++++++
 tb/tb_accum_sched.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/accum_sched_pkg.sv
// accum_sched_pkg: shared default width, opcodes and FSM state encodings for accum_sched.
package accum_sched_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t LATCH = 2'd1;
    localparam state_t EXEC  = 2'd2;
    localparam state_t WRITE = 2'd3;
endpackage

// File: rtl/accum_sched_if.sv
// accum_sched_if: request handshake and accumulator status bundle between requesters and accum_sched.
interface accum_sched_if #(
    parameter int WIDTH = accum_sched_pkg::DEF_WIDTH
);
    logic [1:0]       req_valid;
    logic [1:0]       req_sub;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [1:0]       req_ready;
    logic             acc_clr;
    logic [WIDTH-1:0] acc_out;
    logic             ov_flag;
    logic             done;
    logic             done_id;
    logic             busy;
    modport master (
        output req_valid, req_sub, req_data0, req_data1, acc_clr,
        input  req_ready, acc_out, ov_flag, done, done_id, busy
    );
    modport slave (
        input  req_valid, req_sub, req_data0, req_data1, acc_clr,
        output req_ready, acc_out, ov_flag, done, done_id, busy
    );
endinterface

// File: rtl/accum_alu.sv
// accum_alu: WIDTH+1 bit add/subtract; MSB is carry (add) or borrow (sub).
// Defining ACCUM_SAT_EN clamps overflowing results to all-ones (add) or zero (sub).
module accum_alu
    import accum_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH:0]   res
);
    logic [WIDTH:0] raw;
    always_comb raw = (op == OP_SUB) ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
`ifdef ACCUM_SAT_EN
    always_comb res = raw[WIDTH] ? {1'b1, {WIDTH{op == OP_ADD}}} : raw;
`else
    assign res = raw;
`endif
endmodule

// File: rtl/accum_sched.sv
// accum_sched: two-requester round-robin accumulator with a 4-state LATCH/EXEC/WRITE pipeline.
module accum_sched
    import accum_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    accum_sched_if.slave  bus
);
    state_t           state;
    logic             last;
    logic             win;
    logic [1:0]       grant;
    logic             op_id;
    op_e              op_sub;
    logic [WIDTH-1:0] op_data;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   res;
    logic [WIDTH:0]   alu_res;
    logic             ov;
    logic             done;
    logic             done_id;
    // last holds the previous winner, so the other requester wins a tie
    always_comb begin
        win   = (&bus.req_valid) ? ~last : bus.req_valid[1];
        grant = (state == IDLE && !bus.acc_clr && !reset && |bus.req_valid) ? 2'b01 << win : 2'b00;
    end
    accum_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (acc),
        .b   (op_data),
        .op  (op_sub),
        .res (alu_res)
    );
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state   <= IDLE;
            last    <= 1'b1;
            op_id   <= 1'b0;
            op_sub  <= OP_ADD;
            op_data <= '0;
            res     <= '0;
            acc     <= '0;
            ov      <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
        end else begin
            done <= 1'b0;
            if (bus.acc_clr) begin
                state <= IDLE;
                acc   <= '0;
                ov    <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (|grant) begin
                        state   <= LATCH;
                        last    <= win;
                        op_id   <= win;
                        op_sub  <= op_e'(bus.req_sub[win]);
                        op_data <= win ? bus.req_data1 : bus.req_data0;
                    end
                    LATCH: state <= EXEC;
                    EXEC: begin
                        res   <= alu_res;
                        state <= WRITE;
                    end
                    WRITE: begin
                        acc     <= res[WIDTH-1:0];
                        ov      <= ov | res[WIDTH];
                        done    <= 1'b1;
                        done_id <= op_id;
                        state   <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign bus.req_ready = grant;
    assign bus.acc_out   = acc;
    assign bus.ov_flag   = ov;
    assign bus.done      = done;
    assign bus.done_id   = done_id;
    assign bus.busy      = state != IDLE;
endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: randomized and directed stimulus against a transaction-level accumulator model with a done scoreboard.
module tb_accum_sched;
    typedef struct {
        int         due;
        bit         id;
        logic [7:0] acc;
        bit         ov;
    } exp_t;
`ifdef ACCUM_SAT_EN
    localparam logic [7:0] E37 = 8'hFF, E38 = 8'h00, E38B = 8'h01;
`else
    localparam logic [7:0] E37 = 8'h10, E38 = 8'hFD, E38B = 8'hFE;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    accum_sched_if #(.WIDTH(8)) bus();
    accum_sched #(.WIDTH(8)) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );
    exp_t       sb[$];
    int         total = 0, bad = 0, edge_n = 0, acc_e = 0;
    bit         inflight = 0, prio = 0, m_ov = 0, pend_ov = 0;
    logic [7:0] m_acc = 8'h00, pend_acc = 8'h00;
    logic [1:0] dut_ready = 2'b00;
    always @(posedge clk) edge_n++;
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", n, a, e, $time);
        end
    endtask
    // model of the accumulator as of the coming rising edge, given the inputs now driven
    task automatic model_edge(output logic [1:0] exp_ready);
        int e, r;
        bit id, s, o;
        logic [7:0] d;
        e = edge_n + 1;
        exp_ready = 2'b00;
        id = (bus.req_valid == 2'b11) ? prio : !bus.req_valid[0];
        if (reset || bus.acc_clr) begin
            if (inflight) void'(sb.pop_back());
            inflight = 0;
            m_acc = 8'h00;
            m_ov = 0;
            if (reset) prio = 0;
        end else if (inflight) begin
            if (e == acc_e + 3) begin
                m_acc = pend_acc;
                m_ov = pend_ov;
                inflight = 0;
            end
        end else if (bus.req_valid != 2'b00) begin
            exp_ready = 2'b01 << id;
            d = id ? bus.req_data1 : bus.req_data0;
            s = bus.req_sub[id];
            r = s ? int'(m_acc) - int'(d) : int'(m_acc) + int'(d);
            o = (r < 0) || (r > 255);
`ifdef ACCUM_SAT_EN
            if (o) r = s ? 0 : 255;
`endif
            pend_acc = r[7:0];
            pend_ov = m_ov | o;
            prio = !id;
            inflight = 1;
            acc_e = e;
            sb.push_back('{e + 3, id, pend_acc, pend_ov});
        end
    endtask
    task automatic tick();
        logic [1:0] er;
        #1;
        dut_ready = bus.req_ready;
        model_edge(er);
        chk("req_ready", dut_ready, er);
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic idle(input int n);
        bus.req_valid = 2'b00;
        bus.acc_clr = 1'b0;
        repeat (n) tick();
    endtask
    task automatic clear();
        bus.acc_clr = 1'b1;
        tick();
        bus.acc_clr = 1'b0;
    endtask
    task automatic op(input bit id, input bit s, input logic [7:0] d, output int n);
        bus.req_valid = 2'b01 << id;
        bus.req_sub = {s, s};
        if (id) bus.req_data1 = d;
        else bus.req_data0 = d;
        n = 0;
        do begin
            tick();
            n++;
        end while (dut_ready[id] == 1'b0 && n < 12);
        if (dut_ready[id] == 1'b0) chk("accept_timeout", 0, 1);
        bus.req_valid = 2'b00;
    endtask
    initial begin : monitor
        bit   exp_done;
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            exp_done = sb.size() > 0 && sb[0].due == edge_n;
            chk("done", bus.done, exp_done);
            if (bus.done && exp_done) begin
                e = sb.pop_front();
                chk("done_id", bus.done_id, e.id);
                chk("done_acc", bus.acc_out, e.acc);
                chk("done_ov", bus.ov_flag, e.ov);
            end
            chk("acc_out", bus.acc_out, m_acc);
            chk("ov_flag", bus.ov_flag, m_ov);
            chk("busy", bus.busy, inflight);
        end
    end
    initial begin : stim
        int n;
        bit ids[$];
        bus.req_valid = 2'b00;
        bus.req_sub = 2'b00;
        bus.req_data0 = 8'h00;
        bus.req_data1 = 8'h00;
        bus.acc_clr = 1'b0;
        @(negedge clk);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_acc", bus.acc_out, 0);
        chk("rst_ov", bus.ov_flag, 0);
        chk("rst_done_id", bus.done_id, 0);
        chk("rst_busy", bus.busy, 0);
        op(0, 0, 8'h05, n);
        idle(4);
        chk("add5", bus.acc_out, 8'h05);
        op(0, 0, 8'h03, n);
        idle(4);
        chk("add3", bus.acc_out, 8'h08);
        chk("add3_ov", bus.ov_flag, 0);
        chk("add3_id", bus.done_id, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.req_valid = 2'b11;
        bus.req_sub = 2'b00;
        bus.req_data0 = 8'h01;
        bus.req_data1 = 8'h01;
        for (int i = 0; i < 40 && ids.size() < 4; i++) begin
            tick();
            if (dut_ready != 2'b00) ids.push_back(dut_ready[1]);
        end
        idle(4);
        chk("rr_count", ids.size(), 4);
        foreach (ids[i]) chk("rr_order", ids[i], i % 2);
        chk("rr_acc", bus.acc_out, 8'h04);
        clear();
        op(0, 0, 8'hF0, n);
        idle(4);
        op(1, 0, 8'h20, n);
        idle(4);
        chk("ovf_acc", bus.acc_out, E37);
        chk("ovf_flag", bus.ov_flag, 1);
        clear();
        op(0, 0, 8'h02, n);
        idle(4);
        op(1, 1, 8'h05, n);
        idle(4);
        chk("borrow_acc", bus.acc_out, E38);
        chk("borrow_flag", bus.ov_flag, 1);
        op(0, 0, 8'h01, n);
        idle(4);
        chk("sticky_acc", bus.acc_out, E38B);
        chk("sticky_flag", bus.ov_flag, 1);
        clear();
        op(0, 0, 8'h09, n);
        tick();
        clear();
        chk("abort_acc", bus.acc_out, 0);
        chk("abort_busy", bus.busy, 0);
        op(1, 0, 8'h07, n);
        chk("abort_next", n, 1);
        idle(4);
        chk("abort_after", bus.acc_out, 8'h07);
        clear();
        op(0, 0, 8'h08, n);
        idle(4);
        chk("pre_rst_acc", bus.acc_out, 8'h08);
        op(1, 0, 8'h03, n);
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("wr_rst_acc", bus.acc_out, 0);
        bus.req_valid = 2'b11;
        bus.req_data0 = 8'h01;
        bus.req_data1 = 8'h02;
        #1;
        chk("wr_rst_rr", bus.req_ready, 2'b01);
        tick();
        idle(4);
        chk("wr_rst_next", bus.acc_out, 8'h01);
        repeat (600) begin
            bus.req_valid = 2'($urandom_range(0, 3));
            bus.req_sub = 2'($urandom_range(0, 3));
            bus.req_data0 = 8'($urandom);
            bus.req_data1 = 8'($urandom);
            bus.acc_clr = ($urandom_range(0, 15) == 0);
            reset = ($urandom_range(0, 63) == 0);
            tick();
        end
        reset = 1'b0;
        idle(6);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
